// File: rtl/regfile_wb_checker.sv
// Register-file writeback checker: loads an expected (reg, data) table, then snoops the write port and compares in order.
// Optional per-entry cycle matching is enabled by defining REGCHK_CYCLE_MATCH_EN.
module regfile_wb_checker #(
  parameter int DW          = 32,
  parameter int AW          = 5,
  parameter int DEPTH       = 16,
  parameter int IW          = 4,
  parameter int MAX_CYCLES  = 1000,
  parameter int IGNORE_ZERO = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load_valid,
  input  logic [AW-1:0] load_reg,
  input  logic [DW-1:0] load_data,
`ifdef REGCHK_CYCLE_MATCH_EN
  input  logic [31:0]   load_cycle,
  output logic          late_flag,
`endif
  output logic          load_ready,
  input  logic          start,
  input  logic          wb_en,
  input  logic [AW-1:0] wb_reg,
  input  logic [DW-1:0] wb_data,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic          timeout,
  output logic [IW:0]   mismatch_count,
  output logic [IW-1:0] fail_index,
  output logic [31:0]   cycle_count
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [IW:0] FULL  = (IW+1)'(DEPTH);
  localparam logic [31:0] LIMIT = 32'(MAX_CYCLES - 1);

  state_t        state;
  logic [IW:0]   count;
  logic [IW:0]   head;

  logic [AW-1:0] tbl_reg  [DEPTH];
  logic [DW-1:0] tbl_data [DEPTH];
`ifdef REGCHK_CYCLE_MATCH_EN
  logic [31:0]   tbl_cycle [DEPTH];
`endif

  logic          load_fire;
  logic [IW:0]   count_next;
  logic          go;
  logic          checked;
  logic [IW-1:0] head_idx;
  logic          value_bad;
  logic          timing_bad;
  logic          bad;
  logic          last;
  logic [IW:0]   mm_next;

  assign load_fire  = (state == IDLE) && load_valid && (count < FULL);
  assign count_next = count + {{IW{1'b0}}, load_fire};
  // An entry loaded in the same cycle as start is already counted here.
  assign go         = start && (((state == IDLE) && (count_next != '0)) || (state == DONE));
  assign checked    = wb_en && !((IGNORE_ZERO != 0) && (wb_reg == '0));
  assign head_idx   = head[IW-1:0];
  assign value_bad  = (wb_reg != tbl_reg[head_idx]) || (wb_data != tbl_data[head_idx]);
`ifdef REGCHK_CYCLE_MATCH_EN
  assign timing_bad = (cycle_count != tbl_cycle[head_idx]);
`else
  assign timing_bad = 1'b0;
`endif
  assign bad        = value_bad || timing_bad;
  assign last       = checked && (head == count - 1'b1);
  assign mm_next    = (checked && bad && (mismatch_count != '1)) ? mismatch_count + 1'b1
                                                                 : mismatch_count;

  // NOTE: the table is storage, not control state; it is never reset because count=0 already marks it empty.
  always_ff @(posedge clk) begin
    if (load_fire) begin
      tbl_reg[count[IW-1:0]]   <= load_reg;
      tbl_data[count[IW-1:0]]  <= load_data;
`ifdef REGCHK_CYCLE_MATCH_EN
      tbl_cycle[count[IW-1:0]] <= load_cycle;
`endif
    end
  end

  // NOTE: non-blocking assignments keep every register reading pre-edge values of the others.
  always_ff @(posedge clk) begin
    if (rst) begin
      state          <= IDLE;
      count          <= '0;
      head           <= '0;
      load_ready     <= 1'b1;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      timeout        <= 1'b0;
      mismatch_count <= '0;
      fail_index     <= '0;
      cycle_count    <= '0;
`ifdef REGCHK_CYCLE_MATCH_EN
      late_flag      <= 1'b0;
`endif
    end else begin
      if (load_fire) count <= count_next;
      if (go) begin
        state          <= RUN;
        load_ready     <= 1'b0;
        busy           <= 1'b1;
        done           <= 1'b0;
        head           <= '0;
        pass           <= 1'b0;
        timeout        <= 1'b0;
        mismatch_count <= '0;
        fail_index     <= '0;
        cycle_count    <= '0;
`ifdef REGCHK_CYCLE_MATCH_EN
        late_flag      <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: load_ready <= (count_next < FULL);
          RUN: begin
            mismatch_count <= mm_next;
            if (checked) begin
              head <= head + 1'b1;
              if (bad && (mismatch_count == '0)) fail_index <= head_idx;
`ifdef REGCHK_CYCLE_MATCH_EN
              if (!value_bad && timing_bad) late_flag <= 1'b1;
`endif
            end
            // Completion takes priority over the timeout in the final allowed cycle.
            if (last) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (mm_next == '0);
            end else if (cycle_count == LIMIT) begin
              state   <= DONE;
              busy    <= 1'b0;
              done    <= 1'b1;
              timeout <= 1'b1;
              pass    <= 1'b0;
            end else begin
              cycle_count <= cycle_count + 1'b1;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
